// File: rtl/mem_access_master.sv
// mem_access_master: initiator side of a synchronous word-addressed data RAM
// with 1-cycle registered read latency and no byte enables.
// Handles byte/half/word loads (sign/zero extended) and stores, turning
// sub-word stores into a read-modify-write. Misaligned, reserved-size and
// out-of-range requests get an error response without touching memory.
// Optional feature macro: MEM_ACCESS_MASTER_STATS_EN (adds saturating
// stat_loads / stat_stores / stat_errs counters of STAT_W bits).
module mem_access_master #(
  parameter int unsigned DEPTH = 256
`ifdef MEM_ACCESS_MASTER_STATS_EN
  , parameter int unsigned STAT_W = 16
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
`ifdef MEM_ACCESS_MASTER_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_loads,
  output logic [STAT_W-1:0] stat_stores,
  output logic [STAT_W-1:0] stat_errs
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_WAIT,
    S_LD_DATA,
    S_ST_WORD,
    S_RMW_WAIT,
    S_RMW_MERGE,
    S_RMW_WRITE
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  state_t      r_state;
  state_t      w_state_nxt;

  // Request fields captured at acceptance
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;

  // Registered outputs
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  // Next values of the registered outputs
  logic        w_resp_valid_nxt;
  logic        w_resp_err_nxt;
  logic [31:0] w_resp_rdata_nxt;
  logic        w_mem_we_nxt;
  logic [31:0] w_mem_addr_nxt;
  logic [31:0] w_mem_wdata_nxt;

  logic        w_accept;
  logic        w_req_err;
  logic [31:0] w_word_idx;
  logic [31:0] w_load_data;
  logic [31:0] w_merge_data;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_accept   = req_valid && (r_state == S_IDLE);
  assign w_word_idx = {2'b00, req_addr[31:2]};

  // Request legality check evaluated at acceptance
  always_comb begin
    w_req_err = 1'b0;
    if (req_size == SZ_RSVD)                              w_req_err = 1'b1;
    if ((req_size == SZ_HALF) && req_addr[0])             w_req_err = 1'b1;
    if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) w_req_err = 1'b1;
    if (w_word_idx >= DEPTH)                              w_req_err = 1'b1;
  end

  // Lane extraction and sign/zero extension of returned read data
  always_comb begin
    w_byte      = mem_rdata[7:0];
    w_half      = mem_rdata[15:0];
    w_load_data = mem_rdata;
    case (r_lane)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_size)
      SZ_BYTE: w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
      SZ_HALF: w_load_data = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load_data = mem_rdata;
    endcase
  end

  // Replace the addressed lane of the old word with the latched store data
  always_comb begin
    w_merge_data = mem_rdata;
    if (r_size == SZ_BYTE) begin
      case (r_lane)
        2'd0:    w_merge_data[7:0]   = r_wdata[7:0];
        2'd1:    w_merge_data[15:8]  = r_wdata[7:0];
        2'd2:    w_merge_data[23:16] = r_wdata[7:0];
        default: w_merge_data[31:24] = r_wdata[7:0];
      endcase
    end else begin
      if (r_lane[1]) w_merge_data[31:16] = r_wdata[15:0];
      else           w_merge_data[15:0]  = r_wdata[15:0];
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_req_err) begin
          if (!req_we)                 w_state_nxt = S_LD_WAIT;
          else if (req_size == SZ_WORD) w_state_nxt = S_ST_WORD;
          else                         w_state_nxt = S_RMW_WAIT;
        end
      end
      S_LD_WAIT:   w_state_nxt = S_LD_DATA;
      S_LD_DATA:   w_state_nxt = S_IDLE;
      S_ST_WORD:   w_state_nxt = S_IDLE;
      S_RMW_WAIT:  w_state_nxt = S_RMW_MERGE;
      S_RMW_MERGE: w_state_nxt = S_RMW_WRITE;
      S_RMW_WRITE: w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values for the registered memory and response signals
  always_comb begin
    w_resp_valid_nxt = 1'b0;
    w_resp_err_nxt   = r_resp_err;
    w_resp_rdata_nxt = r_resp_rdata;
    w_mem_we_nxt     = 1'b0;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err) begin
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = 1'b1;
            w_resp_rdata_nxt = '0;
          end else begin
            w_mem_addr_nxt = {req_addr[31:2], 2'b00};
            if (req_we && (req_size == SZ_WORD)) begin
              w_mem_we_nxt    = 1'b1;
              w_mem_wdata_nxt = req_wdata;
            end
          end
        end
      end
      S_LD_DATA: begin
        w_resp_valid_nxt = 1'b1;
        w_resp_err_nxt   = 1'b0;
        w_resp_rdata_nxt = w_load_data;
      end
      S_ST_WORD, S_RMW_WRITE: begin
        w_resp_valid_nxt = 1'b1;
        w_resp_err_nxt   = 1'b0;
        w_resp_rdata_nxt = '0;
      end
      S_RMW_MERGE: begin
        w_mem_we_nxt    = 1'b1;
        w_mem_wdata_nxt = w_merge_data;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
    end
  end

  // Capture request attributes on acceptance; ignored until the next one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_size   <= '0;
      r_signed <= 1'b0;
      r_lane   <= '0;
      r_wdata  <= '0;
    end else if (w_accept) begin
      r_size   <= req_size;
      r_signed <= req_signed;
      r_lane   <= req_addr[1:0];
      r_wdata  <= req_wdata;
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

`ifdef MEM_ACCESS_MASTER_STATS_EN
  logic [STAT_W-1:0] r_stat_loads;
  logic [STAT_W-1:0] r_stat_stores;
  logic [STAT_W-1:0] r_stat_errs;
  logic              w_ev_load;
  logic              w_ev_store;
  logic              w_ev_err;

  assign w_ev_err   = (r_state == S_IDLE) && w_accept && w_req_err;
  assign w_ev_load  = (r_state == S_LD_DATA);
  assign w_ev_store = (r_state == S_ST_WORD) || (r_state == S_RMW_WRITE);

  // Saturating response counters, stepped alongside each response pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_loads  <= '0;
      r_stat_stores <= '0;
      r_stat_errs   <= '0;
    end else begin
      if (w_ev_load  && (r_stat_loads  != '1)) r_stat_loads  <= r_stat_loads  + 1'b1;
      if (w_ev_store && (r_stat_stores != '1)) r_stat_stores <= r_stat_stores + 1'b1;
      if (w_ev_err   && (r_stat_errs   != '1)) r_stat_errs   <= r_stat_errs   + 1'b1;
    end
  end

  assign stat_loads  = r_stat_loads;
  assign stat_stores = r_stat_stores;
  assign stat_errs   = r_stat_errs;
`endif

endmodule

// File: tb/tb_mem_access_master.sv
// Testbench for mem_access_master: synchronous RAM model plus a
// request-level reference model (shadow memory + arithmetic lane rules).
module tb_mem_access_master;

  localparam int unsigned DEPTH = 256;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int total;
  int bad;

  logic [31:0] ram [DEPTH];  // attached RAM
  logic [31:0] mm  [DEPTH];  // reference shadow memory

`ifdef MEM_ACCESS_MASTER_STATS_EN
  logic [1:0] stat_loads, stat_stores, stat_errs;
  mem_access_master #(.DEPTH(DEPTH), .STAT_W(2)) dut (
`else
  mem_access_master #(.DEPTH(DEPTH)) dut (
`endif
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ACCESS_MASTER_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM, one-cycle registered read
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[9:2]];
  end

  // Reference model: expected response and memory effect of one request
  task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic e_err, output logic [31:0] e_rdata,
                       output int e_lat, output int e_wecyc,
                       output logic [31:0] e_wdata);
    int unsigned sh;
    logic [31:0] old, mask, v;
    e_err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
            (size == 2'd2 && addr[1:0] != 2'd0) || ((addr >> 2) >= DEPTH);
    e_rdata = 32'd0; e_wdata = 32'd0; e_wecyc = 0;
    if (e_err) begin
      e_lat = 1;
      return;
    end
    old = mm[addr[9:2]];
    sh  = 8 * int'(addr[1:0]);
    mask = (size == 2'd0) ? (32'hFF << sh) : (size == 2'd1) ? (32'hFFFF << sh) : 32'hFFFF_FFFF;
    if (!we) begin
      e_lat = 3;
      v = (old & mask) >> sh;
      if (sgn && size == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (sgn && size == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
      e_rdata = v;
    end else begin
      e_lat   = (size == 2'd2) ? 2 : 4;
      e_wecyc = 1;
      e_wdata = (old & ~mask) | ((wdata << sh) & mask);
      mm[addr[9:2]] = e_wdata;
    end
  endtask

  // Present one request right away, then watch until its response (bounded)
  task automatic drive(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic o_err, output logic [31:0] o_rdata,
                       output int lat, output int wecyc, output logic [31:0] wd,
                       output logic [31:0] wa, output int busy_rdy, output logic rdy_end);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = $urandom; req_size = 2'($urandom);
    req_signed = $urandom; req_addr = $urandom; req_wdata = $urandom;
    lat = 0; wecyc = 0; wd = 32'd0; wa = 32'd0; busy_rdy = 0;
    o_err = 1'b0; o_rdata = 32'd0; rdy_end = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_we) begin wecyc++; wd = mem_wdata; wa = mem_addr; end
      if (resp_valid) begin
        lat = c; o_err = resp_err; o_rdata = resp_rdata; rdy_end = req_ready;
        break;
      end
      if (req_ready) busy_rdy++;
    end
  endtask

  // Run one request through DUT and model and compare everything observable
  task automatic run_check(input string nm, input logic we, input logic [1:0] size,
                           input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
    logic e_err, o_err, rdy_end;
    logic [31:0] e_rdata, e_wdata, o_rdata, wd, wa;
    int e_lat, e_wecyc, lat, wecyc, busy_rdy;
    model(we, size, sgn, addr, wdata, e_err, e_rdata, e_lat, e_wecyc, e_wdata);
    drive(we, size, sgn, addr, wdata, o_err, o_rdata, lat, wecyc, wd, wa, busy_rdy, rdy_end);
    total++; if (lat !== e_lat) begin bad++;
      $display("FAIL %s latency got=%0d exp=%0d (addr=%h size=%0d we=%0d)", nm, lat, e_lat, addr, size, we); end
    total++; if (o_err !== e_err) begin bad++;
      $display("FAIL %s resp_err got=%b exp=%b (addr=%h)", nm, o_err, e_err, addr); end
    total++; if (o_rdata !== e_rdata) begin bad++;
      $display("FAIL %s resp_rdata got=%h exp=%h (addr=%h size=%0d sgn=%b)", nm, o_rdata, e_rdata, addr, size, sgn); end
    total++; if (wecyc !== e_wecyc) begin bad++;
      $display("FAIL %s mem_we cycles got=%0d exp=%0d", nm, wecyc, e_wecyc); end
    if (e_wecyc != 0) begin
      total++; if (wd !== e_wdata) begin bad++;
        $display("FAIL %s mem_wdata got=%h exp=%h", nm, wd, e_wdata); end
      total++; if (wa !== {addr[31:2], 2'b00}) begin bad++;
        $display("FAIL %s mem_addr got=%h exp=%h", nm, wa, {addr[31:2], 2'b00}); end
    end
    total++; if (busy_rdy !== 0 || rdy_end !== 1'b1) begin bad++;
      $display("FAIL %s req_ready busy_high=%0d at_resp=%b exp 0/1", nm, busy_rdy, rdy_end); end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if ({req_ready, resp_valid, resp_err, mem_we} !== 4'b1000) begin bad++;
      $display("FAIL reset flags got rdy/rv/err/we=%b exp=1000", {req_ready, resp_valid, resp_err, mem_we}); end
    total++; if ({resp_rdata, mem_addr, mem_wdata} !== 96'd0) begin bad++;
      $display("FAIL reset data got rdata=%h addr=%h wdata=%h exp all 0", resp_rdata, mem_addr, mem_wdata); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_check("ld_byte_s", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    run_check("ld_half_u", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    run_check("ld_word",   1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    run_check("st_byte",   1'b1, 2'd0, 1'b0, 32'h11, 32'hDEAD_BE3C);
    run_check("ld_after_st", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    run_check("st_half_hi", 1'b1, 2'd1, 1'b0, 32'h16, 32'h1234_9ABC);
    run_check("ld_half_s", 1'b0, 2'd1, 1'b1, 32'h16, 32'h0);
    run_check("st_word",   1'b1, 2'd2, 1'b0, 32'h3FC, 32'hCAFE_F00D);
    run_check("ld_last",   1'b0, 2'd0, 1'b1, 32'h3FF, 32'h0);
  endtask

  task automatic test_errors();
    run_check("err_half_mis", 1'b0, 2'd1, 1'b0, 32'h11, 32'h0);
    run_check("err_word_mis", 1'b1, 2'd2, 1'b0, 32'h12, 32'hFFFF_FFFF);
    run_check("err_rsvd",     1'b1, 2'd3, 1'b0, 32'h10, 32'h1111_1111);
    run_check("err_oob",      1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
    run_check("err_oob_st",   1'b1, 2'd0, 1'b0, 32'hFFFF_FFF0, 32'h55);
    run_check("ok_after_err", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, lo;
    logic [1:0]  sz;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) a = {$urandom_range(250, 262), 2'b00};
      else                           a = {$urandom_range(0, 7), 2'b00};
      lo = 32'($urandom_range(0, 3));
      sz = ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      run_check("rand", 1'($urandom), sz, 1'($urandom), a | lo, $urandom);
    end
  endtask

  task automatic test_reset_abort();
    int seen_we, seen_rv;
    seen_we = 0; seen_rv = 0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h0000_00EE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 0; c < 8 && seen_we == 0; c++) begin
      @(negedge clk);
      if (mem_we) seen_we = 1;
    end
    total++; if (seen_we !== 1) begin bad++;
      $display("FAIL abort reach RMW_WRITE got=%0d exp=1", seen_we); end
    reset = 1'b1;
    #1;
    total++; if ({mem_we, resp_valid, req_ready} !== 3'b001) begin bad++;
      $display("FAIL abort outputs we/rv/rdy got=%b exp=001", {mem_we, resp_valid, req_ready}); end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (resp_valid) seen_rv++;
    end
    total++; if (seen_rv !== 0) begin bad++;
      $display("FAIL abort stray resp_valid got=%0d exp=0", seen_rv); end
`ifdef MEM_ACCESS_MASTER_STATS_EN
    total++; if ({stat_loads, stat_stores, stat_errs} !== 6'd0) begin bad++;
      $display("FAIL abort stats got=%b exp=000000", {stat_loads, stat_stores, stat_errs}); end
`endif
    run_check("abort_unchanged", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
  endtask

`ifdef MEM_ACCESS_MASTER_STATS_EN
  task automatic test_stats();
    apply_reset();
    for (int i = 0; i < 5; i++)
      run_check("stat_st", 1'b1, 2'd2, 1'b0, 32'(8 * i + 64), $urandom);
    @(negedge clk);
    total++; if (stat_stores !== 2'd3) begin bad++;
      $display("FAIL stat_stores got=%0d exp=3", stat_stores); end
    total++; if (stat_loads !== 2'd0 || stat_errs !== 2'd0) begin bad++;
      $display("FAIL stat_loads/errs got=%0d/%0d exp=0/0", stat_loads, stat_errs); end
    run_check("stat_err", 1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
    run_check("stat_ld", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    total++; if ({stat_loads, stat_stores, stat_errs} !== {2'd1, 2'd3, 2'd1}) begin bad++;
      $display("FAIL stats mix got=%0d/%0d/%0d exp=1/3/1", stat_loads, stat_stores, stat_errs); end
  endtask
`endif

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mm[i]  = $urandom;
      ram[i] = mm[i];
    end
    mm[4]  = 32'h8070_F0A5;
    ram[4] = 32'h8070_F0A5;
    test_reset();
    test_directed();
    test_errors();
    test_back_to_back();
    test_reset_abort();
`ifdef MEM_ACCESS_MASTER_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
